pack8to32: RTL and testbench

- Downstream companion to the 32-to-8 word reader. Consumes its byte stream over a ready/valid handshake and repacks four bytes into one 32-bit word, little-endian (first byte is bits [7:0]).
- Emits the words through the standard generator interface (_start/_ready/_valid/_done/_out0) to a word sink or memory writer.
- Word count is captured at _start.
- A short upstream stream (upstream done early) flushes a zero-padded partial word.

---
 rtl/pack8to32_pkg.sv | 12 +
 rtl/pack8to32_if.sv | 28 ++
 rtl/pack8to32_byte_shift_reg.sv | 36 +++
 rtl/pack8to32.sv | 108 ++++++++++
 tb/tb_pack8to32.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pack8to32_pkg.sv
// Shared types and constants for the byte-to-word packer.
package pack_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

  typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

  typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/pack8to32_if.sv
// Byte stream in (in_*) and packed word stream out (_start/_ready/_valid/_done/_out0).
interface pack8to32_if #(
  parameter int WORDS_W = 32
);
  import pack_pkg::*;

  logic signed [WORDS_W-1:0] count;
  logic                      _start;
  logic [31:0]               in_data;
  logic                      in_valid;
  logic                      in_done;
  logic                      in_ready;
  logic                      _ready;
  logic                      _valid;
  logic                      _done;
  logic signed [WORD_W-1:0]  _out0;

  modport slave (
    input  count, _start, in_data, in_valid, in_done, _ready,
    output in_ready, _valid, _done, _out0
  );

  modport master (
    output count, _start, in_data, in_valid, in_done, _ready,
    input  in_ready, _valid, _done, _out0
  );

endinterface

// File: rtl/pack8to32_byte_shift_reg.sv
// Four byte lanes written by index; word_next shows the lanes including this cycle's write.
module byte_shift_reg
  import pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  lane_idx_t         idx,
  input  logic [BYTE_W-1:0] din,
  output logic [WORD_W-1:0] word_next
);

  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] lanes_q, lanes_d;

  always_comb begin
    lanes_d = lanes_q;
    if (clear) begin
      lanes_d = '0;
    end else if (wr_en) begin
      lanes_d[idx] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lanes_q <= '0;
    end else begin
      lanes_q <= lanes_d;
    end
  end

  // Lanes not yet written are zero, so a partial word comes out zero-padded.
  assign word_next = lanes_d;

endmodule

// File: rtl/pack8to32.sv
// Packs a little-endian byte stream into 32-bit words, with a done marker after the last word.
module pack8to32
  import pack_pkg::*;
#(
  parameter int WORDS_W = 32
) (
  input logic          _clock,
  input logic          _reset_n,
  pack8to32_if.slave   bus
);

  localparam lane_idx_t LAST_LANE = lane_idx_t'(BYTES_PER_WORD - 1);

  state_t                    state_q, state_d;
  logic signed [WORDS_W-1:0] cnt_q, cnt_d;
  lane_idx_t                 idx_q, idx_d;
  logic [WORD_W-1:0]         out_q, out_d;
  logic [WORD_W-1:0]         word_next;
  logic                      xfer;
  logic                      lane_clear;
  logic                      lane_wr;
  logic                      unused_in_hi;

  assign unused_in_hi = ^bus.in_data[31:BYTE_W];

  assign bus.in_ready = (state_q == FILL) && _reset_n && !bus._start;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign bus._valid   = (state_q == EMIT) || (state_q == DONE);
  assign bus._done    = (state_q == DONE);
  assign bus._out0    = out_q;

  byte_shift_reg u_lanes (
    .clk       (_clock),
    .rst_n     (_reset_n),
    .clear     (lane_clear),
    .wr_en     (lane_wr),
    .idx       (idx_q),
    .din       (bus.in_data[BYTE_W-1:0]),
    .word_next (word_next)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    out_d      = out_q;
    lane_clear = 1'b0;
    lane_wr    = 1'b0;

    if (bus._start) begin
      cnt_d      = (bus.count < 0) ? '0 : bus.count;
      idx_d      = '0;
      out_d      = '0;
      lane_clear = 1'b1;
      state_d    = (bus.count > 0) ? FILL : DONE;
    end else begin
      unique case (state_q)
        FILL: begin
          if (xfer) begin
            lane_wr = 1'b1;
            idx_d   = idx_q + 1'b1;
            // Early upstream done ends the run after this (possibly partial) word.
            if (idx_q == LAST_LANE || bus.in_done) begin
              out_d   = word_next;
              state_d = EMIT;
              if (bus.in_done) begin
                cnt_d = WORDS_W'(1);
              end
            end
          end
        end
        EMIT: begin
          if (bus._ready) begin
            lane_clear = 1'b1;
            idx_d      = '0;
            if (cnt_q > 0) begin
              cnt_d = cnt_q - WORDS_W'(1);
            end
            state_d = (cnt_q > 1) ? FILL : DONE;
          end
        end
        DONE: begin
          if (bus._ready) begin
            state_d = IDLE;
            out_d   = '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge _clock) begin
    if (!_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_pack8to32.sv
// Table-driven bench for pack8to32 with a word scoreboard checked on every output handshake.
module tb_pack8to32;

  typedef struct {
    int          count;
    int          nbytes;
    logic [63:0] bytes;
    int          done_at;
    bit          gap;
    int          nexp;
    logic [95:0] words;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  vec_t vecs[5];

  pack8to32_if bus();

  pack8to32 dut (
    ._clock   (clk),
    ._reset_n (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  // Scoreboard: every output handshake pops one expected word/done pair.
  always @(negedge clk) begin
    #2;
    if (mon_en && bus._valid === 1'b1) begin
      checkOutput("in_ready_while_valid", 32'(bus.in_ready), 32'd0);
      if (bus._ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_word: got 0x%08h expected no word", bus._out0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("word", bus._out0, e.word);
          checkOutput("done_flag", 32'(bus._done), 32'(e.done));
        end
      end
    end
  end

  task automatic startRun(input int c);
    @(negedge clk);
    bus.count  = c;
    bus._start = 1'b1;
    @(negedge clk);
    bus._start = 1'b0;
    #1;
    if (c <= 0) begin
      checkOutput("empty_valid", 32'(bus._valid), 32'd1);
      checkOutput("empty_done", 32'(bus._done), 32'd1);
      checkOutput("empty_out", bus._out0, 32'd0);
      checkOutput("empty_in_ready", 32'(bus.in_ready), 32'd0);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input bit dn, input bit gap, input bit expect_emit);
    int waited = 0;
    bit ok = 1'b0;
    bus.in_data  = {24'hA5C3E1, b};
    bus.in_valid = 1'b1;
    bus.in_done  = dn;
    while (!ok && waited < 60) begin
      #1;
      ok = bus.in_ready;
      @(negedge clk);
      waited++;
    end
    bus.in_valid = 1'b0;
    bus.in_done  = 1'b0;
    if (!ok) begin
      failNow("byte_accept");
    end else begin
      #1;
      if (expect_emit) checkOutput("valid_latency", 32'(bus._valid), 32'd1);
      else             checkOutput("no_early_valid", 32'(bus._valid), 32'd0);
    end
    // A lone in_done without in_valid must be ignored.
    if (gap) begin
      bus.in_done = 1'b1;
      @(negedge clk);
      bus.in_done = 1'b0;
    end
  endtask

  task automatic drainAndCheckIdle();
    int w = 0;
    while (sb.size() > 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() > 0) begin
      failNow("drain_words");
      sb.delete();
    end else begin
      #1;
      checkOutput("idle_valid", 32'(bus._valid), 32'd0);
      checkOutput("idle_done", 32'(bus._done), 32'd0);
      checkOutput("idle_out", bus._out0, 32'd0);
      checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd0);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int k = 0; k < v.nexp; k++) begin
      sb.push_back('{v.words[32*k +: 32], 1'b0});
    end
    sb.push_back('{(v.nexp > 0) ? v.words[32*(v.nexp-1) +: 32] : 32'h0, 1'b1});
    startRun(v.count);
    for (int i = 0; i < v.nbytes; i++) begin
      sendByte(v.bytes[8*i +: 8], i == v.done_at, v.gap, (i % 4 == 3) || (i == v.done_at));
    end
    drainAndCheckIdle();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{2,  8, 64'h8877665544332211, -1, 1'b0, 2, 96'h0_88776655_44332211};
    vecs[1] = '{3,  2, 64'h0201,              1, 1'b0, 1, 96'h0000_0201};
    vecs[2] = '{0,  0, 64'h0,                -1, 1'b0, 0, 96'h0};
    vecs[3] = '{-5, 0, 64'h0,                -1, 1'b0, 0, 96'h0};
    vecs[4] = '{1,  4, 64'hF0DEBC9A,         -1, 1'b1, 1, 96'hF0DEBC9A};

    rst_n        = 1'b0;
    bus.count    = '0;
    bus._start   = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_done  = 1'b0;
    bus._ready   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_valid", 32'(bus._valid), 32'd0);
    checkOutput("reset_done", 32'(bus._done), 32'd0);
    checkOutput("reset_out", bus._out0, 32'd0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int v = 0; v < 5; v++) begin
      $display("[TB] vector %0d count=%0d", v, vecs[v].count);
      applyStimulus(vecs[v]);
    end

    // Downstream stall: word must hold steady and no byte may be taken.
    $display("[TB] stall sequence");
    sb.push_back('{32'hDDCCBBAA, 1'b0});
    sb.push_back('{32'hDDCCBBAA, 1'b1});
    bus._ready = 1'b0;
    startRun(1);
    sendByte(8'hAA, 1'b0, 1'b0, 1'b0);
    sendByte(8'hBB, 1'b0, 1'b0, 1'b0);
    sendByte(8'hCC, 1'b0, 1'b0, 1'b0);
    sendByte(8'hDD, 1'b0, 1'b0, 1'b1);
    bus.in_data  = 32'h0000_00EE;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checkOutput("stall_out", bus._out0, 32'hDDCCBBAA);
      checkOutput("stall_valid", 32'(bus._valid), 32'd1);
      checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus._ready   = 1'b1;
    drainAndCheckIdle();

    // Reset mid-word, then a fresh word must carry no stale bytes.
    $display("[TB] reset mid-word sequence");
    startRun(2);
    sendByte(8'h01, 1'b0, 1'b0, 1'b0);
    sendByte(8'h02, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midreset_valid", 32'(bus._valid), 32'd0);
    checkOutput("midreset_done", 32'(bus._done), 32'd0);
    checkOutput("midreset_out", bus._out0, 32'd0);
    checkOutput("midreset_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    sb.push_back('{32'h40302010, 1'b0});
    sb.push_back('{32'h40302010, 1'b1});
    startRun(1);
    sendByte(8'h10, 1'b0, 1'b0, 1'b0);
    sendByte(8'h20, 1'b0, 1'b0, 1'b0);
    sendByte(8'h30, 1'b0, 1'b0, 1'b0);
    sendByte(8'h40, 1'b0, 1'b0, 1'b1);
    drainAndCheckIdle();

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
